// File: rtl/sparse_pe_merge_if.sv
// One sparse stream lane: a (value, index) pair framed by valid and last.
// The master modport drives the lane and the slave modport receives it.
interface sparse_pe_merge_if #(
    parameter int DATA_WIDTH = 8,
    parameter int INDEX_SIZE = 3
);
    logic [DATA_WIDTH-1:0] data;
    logic [INDEX_SIZE-1:0] index;
    logic                  valid;
    logic                  last;

    modport master (output data, index, valid, last);
    modport slave  (input  data, index, valid, last);
endinterface

// File: rtl/sparse_pe_merge.sv
// Sparse dot-product PE: per-side FIFOs feed a two-pointer merge on ascending indices.
// The input lanes are also registered straight through to down/right so PEs tile into a grid.
module sparse_pe_merge #(
    parameter int DATA_WIDTH = 8,
    parameter int INDEX_SIZE = 3,
    parameter int FRAC_BITS  = 4,
    parameter int ACC_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    sparse_pe_merge_if.slave     up,
    sparse_pe_merge_if.slave     left,
    sparse_pe_merge_if.master    down,
    sparse_pe_merge_if.master    right,
    output logic [ACC_WIDTH-1:0] o_result,
    output logic                 result_valid,
    output logic                 finished,
    output logic                 overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = INDEX_SIZE + DATA_WIDTH + 1;
    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = ((PW > ACC_WIDTH) ? PW : ACC_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;

    logic [EW-1:0]         mem_u [FIFO_DEPTH];
    logic [EW-1:0]         mem_l [FIFO_DEPTH];
    logic [AW:0]           wr_u, rd_u, wr_l, rd_l;
    logic                  done_u, done_l;
    logic [ACC_WIDTH-1:0]  acc, acc_next;
    logic                  empty_u, empty_l, full_u, full_l;
    logic [EW-1:0]         head_u, head_l;
    logic                  pop_u, pop_l, match, flush, push_u, push_l;
    logic [PW-1:0]         prod_shift;
    logic [SW-1:0]         sum;

    assign empty_u = (wr_u == rd_u);
    assign empty_l = (wr_l == rd_l);
    assign full_u  = (wr_u == {~rd_u[AW], rd_u[AW-1:0]});
    assign full_l  = (wr_l == {~rd_l[AW], rd_l[AW-1:0]});
    assign head_u  = mem_u[rd_u[AW-1:0]];
    assign head_l  = mem_l[rd_l[AW-1:0]];

    // Once one side's last element has been popped nothing else of that side can
    // match, so the vector ends there; anything still queued belongs to the next vector.
    always_comb begin
        pop_u = 1'b0;
        pop_l = 1'b0;
        match = 1'b0;
        flush = 1'b0;
        if (state == RUN) begin
            if (done_u || done_l) begin
                flush = 1'b1;
            end else if (!empty_u && !empty_l) begin
                if (head_u[EW-2:DATA_WIDTH] == head_l[EW-2:DATA_WIDTH]) begin
                    pop_u = 1'b1;
                    pop_l = 1'b1;
                    match = 1'b1;
                end else if (head_u[EW-2:DATA_WIDTH] < head_l[EW-2:DATA_WIDTH]) begin
                    pop_u = 1'b1;
                end else begin
                    pop_l = 1'b1;
                end
            end
        end
    end

    assign push_u = up.valid   && (flush || pop_u || !full_u);
    assign push_l = left.valid && (flush || pop_l || !full_l);

    assign prod_shift = (PW'(head_u[DATA_WIDTH-1:0]) * PW'(head_l[DATA_WIDTH-1:0])) >> FRAC_BITS;
    assign sum        = SW'(acc) + SW'(prod_shift);
    assign acc_next   = (SATURATE && (|sum[SW-1:ACC_WIDTH])) ? '1 : sum[ACC_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (push_u) mem_u[wr_u[AW-1:0]] <= {up.last, up.index, up.data};
        if (push_l) mem_l[wr_l[AW-1:0]] <= {left.last, left.index, left.data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            o_result     <= '0;
            result_valid <= 1'b0;
            finished     <= 1'b0;
            overflow     <= 1'b0;
            wr_u         <= '0;
            rd_u         <= '0;
            wr_l         <= '0;
            rd_l         <= '0;
            done_u       <= 1'b0;
            done_l       <= 1'b0;
            down.data    <= '0;
            down.index   <= '0;
            down.valid   <= 1'b0;
            down.last    <= 1'b0;
            right.data   <= '0;
            right.index  <= '0;
            right.valid  <= 1'b0;
            right.last   <= 1'b0;
        end else begin
            down.data   <= up.data;
            down.index  <= up.index;
            down.valid  <= up.valid;
            down.last   <= up.last;
            right.data  <= left.data;
            right.index <= left.index;
            right.valid <= left.valid;
            right.last  <= left.last;
            finished    <= 1'b0;

            // A flush empties the FIFO first, so a same-cycle push lands as the sole entry.
            if (flush)      rd_u <= wr_u;
            else if (pop_u) rd_u <= rd_u + 1'b1;
            if (flush)      rd_l <= wr_l;
            else if (pop_l) rd_l <= rd_l + 1'b1;
            if (push_u) wr_u <= wr_u + 1'b1;
            if (push_l) wr_l <= wr_l + 1'b1;
            if ((up.valid && !push_u) || (left.valid && !push_l)) overflow <= 1'b1;

            if (flush)                      done_u <= 1'b0;
            else if (pop_u && head_u[EW-1]) done_u <= 1'b1;
            if (flush)                      done_l <= 1'b0;
            else if (pop_l && head_l[EW-1]) done_l <= 1'b1;

            case (state)
                IDLE: begin
                    acc <= '0;
                    if (up.valid || left.valid) state <= RUN;
                end
                RUN: begin
                    if (flush) begin
                        o_result     <= acc;
                        result_valid <= 1'b1;
                        finished     <= 1'b1;
                        state        <= DONE;
                    end else if (match) begin
                        acc <= acc_next;
                    end
                end
                DONE: begin
                    // Elements pushed during the flush cycle also start the next vector.
                    if (up.valid || left.valid || !empty_u || !empty_l) begin
                        acc          <= '0;
                        result_valid <= 1'b0;
                        state        <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sparse_pe_merge.sv
// Directed bench for sparse_pe_merge: one shared stimulus drives four parameter variants
// (default, 8-bit saturating, 8-bit wrapping, depth-2 FIFO) with hand-computed results.
module tb_sparse_pe_merge;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    sparse_pe_merge_if #(.DATA_WIDTH(8), .INDEX_SIZE(3)) in_up ();
    sparse_pe_merge_if #(.DATA_WIDTH(8), .INDEX_SIZE(3)) in_left ();
    sparse_pe_merge_if #(.DATA_WIDTH(8), .INDEX_SIZE(3)) dn0 ();
    sparse_pe_merge_if #(.DATA_WIDTH(8), .INDEX_SIZE(3)) rt0 ();
    sparse_pe_merge_if #(.DATA_WIDTH(8), .INDEX_SIZE(3)) dn1 ();
    sparse_pe_merge_if #(.DATA_WIDTH(8), .INDEX_SIZE(3)) rt1 ();
    sparse_pe_merge_if #(.DATA_WIDTH(8), .INDEX_SIZE(3)) dn2 ();
    sparse_pe_merge_if #(.DATA_WIDTH(8), .INDEX_SIZE(3)) rt2 ();
    sparse_pe_merge_if #(.DATA_WIDTH(8), .INDEX_SIZE(3)) dn3 ();
    sparse_pe_merge_if #(.DATA_WIDTH(8), .INDEX_SIZE(3)) rt3 ();

    logic [15:0] res0, res_d2;
    logic [7:0]  res_s8, res_w8;
    logic        rv0, rv_s8, rv_w8, rv_d2;
    logic        fin0, fin_s8, fin_w8, fin_d2;
    logic        ovf0, ovf_s8, ovf_w8, ovf_d2;

    sparse_pe_merge dut (
        .clk(clk), .rst(rst), .up(in_up), .left(in_left), .down(dn0), .right(rt0),
        .o_result(res0), .result_valid(rv0), .finished(fin0), .overflow(ovf0));
    sparse_pe_merge #(.ACC_WIDTH(8), .SATURATE(1'b1)) dut_s8 (
        .clk(clk), .rst(rst), .up(in_up), .left(in_left), .down(dn1), .right(rt1),
        .o_result(res_s8), .result_valid(rv_s8), .finished(fin_s8), .overflow(ovf_s8));
    sparse_pe_merge #(.ACC_WIDTH(8), .SATURATE(1'b0)) dut_w8 (
        .clk(clk), .rst(rst), .up(in_up), .left(in_left), .down(dn2), .right(rt2),
        .o_result(res_w8), .result_valid(rv_w8), .finished(fin_w8), .overflow(ovf_w8));
    sparse_pe_merge #(.FIFO_DEPTH(2)) dut_d2 (
        .clk(clk), .rst(rst), .up(in_up), .left(in_left), .down(dn3), .right(rt3),
        .o_result(res_d2), .result_valid(rv_d2), .finished(fin_d2), .overflow(ovf_d2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // Apply one cycle of input, clock it, and check every variant forwarded it.
    task automatic send(input logic uv, input logic [2:0] ui, input logic [7:0] ud, input logic ul,
                        input logic lv, input logic [2:0] li, input logic [7:0] ld, input logic ll);
        logic [12:0] eu, el;
        in_up.valid = uv;   in_up.index = ui;   in_up.data = ud;   in_up.last = ul;
        in_left.valid = lv; in_left.index = li; in_left.data = ld; in_left.last = ll;
        eu = {uv, ul, ui, ud};
        el = {lv, ll, li, ld};
        @(posedge clk);
        #1;
        chk("fwd_down",    32'({dn0.valid, dn0.last, dn0.index, dn0.data}), 32'(eu));
        chk("fwd_right",   32'({rt0.valid, rt0.last, rt0.index, rt0.data}), 32'(el));
        chk("fwd_down_s8", 32'({dn1.valid, dn1.last, dn1.index, dn1.data}), 32'(eu));
        chk("fwd_right_s8",32'({rt1.valid, rt1.last, rt1.index, rt1.data}), 32'(el));
        chk("fwd_down_w8", 32'({dn2.valid, dn2.last, dn2.index, dn2.data}), 32'(eu));
        chk("fwd_right_w8",32'({rt2.valid, rt2.last, rt2.index, rt2.data}), 32'(el));
        chk("fwd_down_d2", 32'({dn3.valid, dn3.last, dn3.index, dn3.data}), 32'(eu));
        chk("fwd_right_d2",32'({rt3.valid, rt3.last, rt3.index, rt3.data}), 32'(el));
    endtask

    task automatic idle();
        send(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    endtask

    // Idle until result_valid (bounded), then one more cycle; finished must pulse exactly once.
    task automatic wait_done(input string tag);
        int pulses = 0;
        int n = 0;
        while (!rv0 && n < 40) begin
            idle();
            if (fin0) pulses++;
            n++;
        end
        chk({tag, "_result_valid"}, 32'(rv0), 32'd1);
        idle();
        if (fin0) pulses++;
        chk({tag, "_finished_pulses"}, 32'(pulses), 32'd1);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk({tag, "_o_result"}, 32'(res0), 32'd0);
        chk({tag, "_flags"}, 32'({rv0, fin0, ovf0, ovf_d2, rv_s8, rv_w8}), 32'd0);
        chk({tag, "_down"},  32'({dn0.valid, dn0.last, dn0.index, dn0.data}), 32'd0);
        chk({tag, "_right"}, 32'({rt0.valid, rt0.last, rt0.index, rt0.data}), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        in_up.valid = 1'b0;   in_up.index = '0;   in_up.data = '0;   in_up.last = 1'b0;
        in_left.valid = 1'b0; in_left.index = '0; in_left.data = '0; in_left.last = 1'b0;
        @(posedge clk);
        #1;
        do_reset("reset");

        // T1 dense match: 4 * (0x20*0x20 >> 4) = 0x100
        for (int i = 0; i < 4; i++)
            send(1'b1, 3'(i), 8'h20, i == 3, 1'b1, 3'(i), 8'h20, i == 3);
        wait_done("t1");
        chk("t1_o_result", 32'(res0), 32'h100);

        // T2 disjoint indices straight out of DONE: acc must restart from 0
        send(1'b1, 3'd1, 8'd10, 1'b0, 1'b1, 3'd0, 8'd40, 1'b0);
        chk("t2_result_valid_cleared", 32'(rv0), 32'd0);
        send(1'b1, 3'd3, 8'd20, 1'b0, 1'b1, 3'd2, 8'd50, 1'b0);
        send(1'b1, 3'd5, 8'd30, 1'b1, 1'b1, 3'd4, 8'd60, 1'b1);
        wait_done("t2");
        chk("t2_o_result", 32'(res0), 32'd0);

        // T3 partial overlap: (32*48>>4) + (16*16>>4) = 112
        send(1'b1, 3'd0, 8'd16, 1'b0, 1'b1, 3'd2, 8'd48, 1'b0);
        send(1'b1, 3'd2, 8'd32, 1'b0, 1'b1, 3'd5, 8'd1,  1'b0);
        send(1'b1, 3'd7, 8'd16, 1'b1, 1'b1, 3'd7, 8'd16, 1'b1);
        wait_done("t3");
        chk("t3_o_result", 32'(res0), 32'd112);

        // T4 left lags by 5 cycles; terms (i+1)*24>>4 = 1,3,4,6,7,9,10,12 -> 52
        do_reset("t4_reset");
        for (int c = 0; c < 13; c++)
            send(c < 8, 3'(c), 8'(c + 1), c == 7,
                 c >= 5, 3'(c - 5), 8'd24, c == 12);
        wait_done("t4");
        chk("t4_o_result", 32'(res0), 32'd52);
        chk("t4_overflow_depth8", 32'(ovf0), 32'd0);
        chk("t4_overflow_depth2", 32'(ovf_d2), 32'd1);

        // T5 eight matches of 255*255>>4 = 4064: 0x7F00 at 16 bits, clamp 255, wrap 0
        do_reset("t5_reset");
        for (int i = 0; i < 8; i++)
            send(1'b1, 3'(i), 8'hFF, i == 7, 1'b1, 3'(i), 8'hFF, i == 7);
        wait_done("t5");
        chk("t5_o_result", 32'(res0), 32'h7F00);
        chk("t5_saturated", 32'(res_s8), 32'd255);
        chk("t5_wrapped", 32'(res_w8), 32'd0);
        chk("t5_variant_valid", 32'({rv_s8, rv_w8, rv_d2, fin_s8, fin_w8, fin_d2}), 32'b111000);
        chk("t5_depth2_result", 32'(res_d2), 32'h7F00);
        chk("t5_overflow_depth2", 32'(ovf_d2), 32'd0);
        chk("t5_overflow_s8_w8", 32'({ovf_s8, ovf_w8}), 32'd0);

        // T6 reset after two matches, with inputs active during reset
        send(1'b1, 3'd0, 8'h20, 1'b0, 1'b1, 3'd0, 8'h20, 1'b0);
        send(1'b1, 3'd1, 8'h20, 1'b0, 1'b1, 3'd1, 8'h20, 1'b0);
        idle();
        idle();
        in_up.valid = 1'b1;   in_up.index = 3'd2;   in_up.data = 8'h55;   in_up.last = 1'b1;
        in_left.valid = 1'b1; in_left.index = 3'd2; in_left.data = 8'hAA; in_left.last = 1'b1;
        do_reset("t6_reset");
        send(1'b1, 3'd0, 8'h20, 1'b1, 1'b1, 3'd0, 8'h20, 1'b1);
        wait_done("t6");
        chk("t6_o_result", 32'(res0), 32'h40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
